// File: rtl/dmem_wbuf_if.sv
// Core-side store/load handshake and SRAM port bundle for dmem_wbuf.
// The slave modport is the buffer; the master modport is its environment (core + SRAM).
interface dmem_wbuf_if;
  logic        c_wready;
  logic        c_wvalid;
  logic [31:0] c_waddr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_rready;
  logic        c_rvalid;
  logic [31:0] c_raddr;
  logic        c_rresp;
  logic [31:0] c_rdata;
  logic        m_en;
  logic        m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        wb_busy;
  logic        wb_full;

  modport slave (
    input  c_wready, c_waddr, c_wdata, c_wstrb, c_rready, c_raddr, m_rdata,
    output c_wvalid, c_rvalid, c_rresp, c_rdata, m_en, m_we, m_addr, m_wdata, m_wstrb,
           wb_busy, wb_full
  );

  modport master (
    output c_wready, c_waddr, c_wdata, c_wstrb, c_rready, c_raddr, m_rdata,
    input  c_wvalid, c_rvalid, c_rresp, c_rdata, m_en, m_we, m_addr, m_wdata, m_wstrb,
           wb_busy, wb_full
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Posted-write store buffer in front of a single-port synchronous data SRAM.
// Loads win the port unless the buffer is full or the load hits a buffered store.
module dmem_wbuf #(
  parameter int unsigned DEPTH = 4
) (
  input logic        clk,
  input logic        resetb,
  dmem_wbuf_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count;
  logic [PW-1:0] count_nxt;
  logic          busy_q;
  logic          full_q;
  logic          rresp_q;
  logic          wvalid;
  logic          hazard;
  logic          do_read;
  logic          do_drain;
  entry_t        head_e;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.c_waddr[1:0], bus.c_raddr[1:0]};

  assign head_e   = mem[head[AW-1:0]];
  assign wvalid   = resetb & bus.c_wready & ~full_q;
  // Full forces a drain; otherwise a hazard-free read takes the port ahead of draining.
  assign do_read  = resetb & bus.c_rready & ~hazard & ~full_q;
  assign do_drain = busy_q & ~do_read;

  // Hazard against every live entry plus a store entering this cycle.
  always_comb begin
    hazard = wvalid && (bus.c_waddr[31:2] == bus.c_raddr[31:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((PW'(i) < count) &&
          (mem[AW'(head[AW-1:0] + AW'(i))].addr == bus.c_raddr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    bus.c_wvalid = wvalid;
    bus.c_rvalid = do_read;
    bus.m_en     = do_read | do_drain;
    bus.m_we     = do_drain;
    bus.m_addr   = 30'd0;
    bus.m_wdata  = 32'd0;
    bus.m_wstrb  = 4'd0;
    if (do_drain) begin
      bus.m_addr  = head_e.addr;
      bus.m_wdata = head_e.data;
      bus.m_wstrb = head_e.strb;
    end else if (do_read) begin
      bus.m_addr = bus.c_raddr[31:2];
    end
  end

  assign bus.c_rresp = rresp_q;
  assign bus.c_rdata = rresp_q ? bus.m_rdata : 32'd0;
  assign bus.wb_busy = busy_q;
  assign bus.wb_full = full_q;

  assign count_nxt = count + PW'(wvalid) - PW'(do_drain);

  // Pointers keep their top bit clear and wrap modulo DEPTH.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      rresp_q <= 1'b0;
    end else begin
      if (wvalid) tail <= PW'(AW'(tail[AW-1:0] + AW'(1)));
      if (do_drain) head <= PW'(AW'(head[AW-1:0] + AW'(1)));
      count   <= count_nxt;
      busy_q  <= (count_nxt != '0);
      full_q  <= (count_nxt == PW'(DEPTH));
      rresp_q <= do_read;
    end
  end

  // Entry storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (wvalid) begin
      mem[tail[AW-1:0]] <= '{addr: bus.c_waddr[31:2], data: bus.c_wdata, strb: bus.c_wstrb};
    end
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: vector table plus hand sequences, with
// write-order and read-data scoreboards against a bench-side reference memory.
module tb_dmem_wbuf;
  logic clk;
  logic resetb;
  dmem_wbuf_if bus ();

  dmem_wbuf #(.DEPTH(4)) dut (.clk(clk), .resetb(resetb), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rd;
    logic [31:0] ra;
    logic        wv;
    logic        rv;
    logic        men;
    logic        mwe;
    logic [29:0] ma;
    logic [31:0] mwd;
    logic        busy;
    logic        full;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int          checks;
  int          failures;
  bit [31:0]   sram    [256];
  bit [31:0]   ref_mem [256];
  wr_t         wq [$];
  logic [31:0] rq [$];
  vec_t        vecs [$];

  // SRAM model: byte-strobed write, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_wstrb[b]) sram[bus.m_addr[7:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end else begin
        bus.m_rdata <= sram[bus.m_addr[7:0]];
      end
    end
  end

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d, input logic [3:0] s);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic rd, input logic [31:0] ra);
    bus.c_wready = wr;
    bus.c_waddr  = wa;
    bus.c_wdata  = wd;
    bus.c_wstrb  = ws;
    bus.c_rready = rd;
    bus.c_raddr  = ra;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current read request until accepted; drop it after the accept edge.
  task automatic wait_rvalid(input string name, input int bound);
    int n;
    n = 0;
    while (!bus.c_rvalid && n < bound) begin
      tick();
      #3;
      n++;
    end
    chk({name, "_accept"}, 32'(bus.c_rvalid), 32'd1);
    tick();
    idle();
    #3;
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  task automatic monitor();
    wr_t  w;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        wq.delete();
        rq.delete();
        ref_mem = sram;
      end else begin
        if (bus.c_rresp) begin
          if (rq.size() == 0) chk("rresp_unexpected", 32'(bus.c_rresp), 32'd0);
          else begin
            e = rq.pop_front();
            chk("rdata", bus.c_rdata, e);
          end
        end
        if (bus.m_en && bus.m_we) begin
          if (wq.size() == 0) chk("drain_unexpected", 32'(bus.m_we), 32'd0);
          else begin
            w = wq.pop_front();
            chk("drain_addr", 32'(bus.m_addr), 32'(w.addr));
            chk("drain_data", bus.m_wdata, w.data);
            chk("drain_strb", 32'(bus.m_wstrb), 32'(w.strb));
          end
        end
        if (bus.c_rvalid) begin
          chk("read_port", {bus.m_en, bus.m_we, bus.m_addr}, {1'b1, 1'b0, bus.c_raddr[31:2]});
          rq.push_back(ref_mem[bus.c_raddr[9:2]]);
        end
        if (bus.c_wvalid) begin
          wq.push_back('{addr: bus.c_waddr[31:2], data: bus.c_wdata, strb: bus.c_wstrb});
          ref_mem[bus.c_waddr[9:2]] = merge(ref_mem[bus.c_waddr[9:2]], bus.c_wdata, bus.c_wstrb);
        end
      end
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                              input logic rd, input logic [31:0] ra,
                              input logic wv, input logic rv, input logic men, input logic mwe,
                              input logic [29:0] ma, input logic [31:0] mwd,
                              input logic busy, input logic full);
    vec_t v;
    v = '{wr, wa, wd, rd, ra, wv, rv, men, mwe, ma, mwd, busy, full};
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    resetb   = 1'b0;
    idle();
    fork
      monitor();
    join_none

    // Single store then idle.
    vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 0, 0,      1, 0, 0, 0, 30'h0,  32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0,                 0, 0,      0, 0, 1, 1, 30'h4,  32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 0,                 0, 0,      0, 0, 0, 0, 30'h0,  32'h0,        0, 0));
    // Fill to full with a competing non-hazard read of 0x100.
    vecs.push_back(mk(1, 32'h200, 32'hA0000000, 1, 32'h100, 1, 1, 1, 0, 30'h40, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h204, 32'hA0000001, 1, 32'h100, 1, 1, 1, 0, 30'h40, 32'h0,        1, 0));
    vecs.push_back(mk(1, 32'h208, 32'hA0000002, 1, 32'h100, 1, 1, 1, 0, 30'h40, 32'h0,        1, 0));
    vecs.push_back(mk(1, 32'h20C, 32'hA0000003, 1, 32'h100, 1, 1, 1, 0, 30'h40, 32'h0,        1, 0));
    vecs.push_back(mk(1, 32'h210, 32'hA0000004, 1, 32'h100, 0, 0, 1, 1, 30'h80, 32'hA0000000, 1, 1));
    vecs.push_back(mk(1, 32'h210, 32'hA0000004, 1, 32'h100, 1, 1, 1, 0, 30'h40, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 0,                   1, 32'h100, 0, 0, 1, 1, 30'h81, 32'hA0000001, 1, 1));
    vecs.push_back(mk(0, 0, 0,                   0, 0,       0, 0, 1, 1, 30'h82, 32'hA0000002, 1, 0));
    vecs.push_back(mk(0, 0, 0,                   0, 0,       0, 0, 1, 1, 30'h83, 32'hA0000003, 1, 0));
    vecs.push_back(mk(0, 0, 0,                   0, 0,       0, 0, 1, 1, 30'h84, 32'hA0000004, 1, 0));
    vecs.push_back(mk(0, 0, 0,                   0, 0,       0, 0, 0, 0, 30'h0,  32'h0,        0, 0));

    // Reset state, with requests held to show acceptance is suppressed.
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 32'h10, 32'h1, 4'hF, 1'b1, 32'h100);
    #1;
    chk("rst_wvalid", 32'(bus.c_wvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("rst_men", 32'(bus.m_en), 32'd0);
    chk("rst_rresp", 32'(bus.c_rresp), 32'd0);
    chk("rst_rdata", bus.c_rdata, 32'd0);
    chk("rst_mbus", {bus.m_addr, bus.m_wstrb}, 34'd0);
    chk("rst_mwdata", bus.m_wdata, 32'd0);
    chk("rst_flags", {bus.wb_busy, bus.wb_full}, 32'd0);
    idle();
    tick();
    resetb = 1'b1;
    tick();

    foreach (vecs[k]) begin
      drive(vecs[k].wr, vecs[k].wa, vecs[k].wd, 4'hF, vecs[k].rd, vecs[k].ra);
      #3;
      chk($sformatf("v%0d_wvalid", k), 32'(bus.c_wvalid), 32'(vecs[k].wv));
      chk($sformatf("v%0d_rvalid", k), 32'(bus.c_rvalid), 32'(vecs[k].rv));
      chk($sformatf("v%0d_men", k), 32'(bus.m_en), 32'(vecs[k].men));
      chk($sformatf("v%0d_mwe", k), 32'(bus.m_we), 32'(vecs[k].mwe));
      chk($sformatf("v%0d_maddr", k), 32'(bus.m_addr), 32'(vecs[k].ma));
      chk($sformatf("v%0d_mwdata", k), bus.m_wdata, vecs[k].mwd);
      chk($sformatf("v%0d_busy", k), 32'(bus.wb_busy), 32'(vecs[k].busy));
      chk($sformatf("v%0d_full", k), 32'(bus.wb_full), 32'(vecs[k].full));
      tick();
    end

    // Read-after-write hazard with a partial-strobe store over a known word.
    drive(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 32'd0);
    tick();
    idle();
    tick();
    drive(1'b1, 32'h20, 32'h11223344, 4'h3, 1'b0, 32'd0);
    #3;
    chk("haz_wvalid", 32'(bus.c_wvalid), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h20);
    #3;
    chk("haz_stall", 32'(bus.c_rvalid), 32'd0);
    chk("haz_drain", {bus.m_we, bus.m_addr}, {1'b1, 30'h8});
    wait_rvalid("haz", 6);
    chk("haz_rresp", 32'(bus.c_rresp), 32'd1);
    chk("haz_rdata", bus.c_rdata, 32'hAABB3344);
    tick();

    // Non-hazard read beats draining of two buffered stores.
    drive(1'b1, 32'h40, 32'hB0B0B0B0, 4'hF, 1'b0, 32'd0);
    tick();
    drive(1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, 1'b1, 32'h80);
    #3;
    chk("pri_read", {bus.c_wvalid, bus.c_rvalid, bus.m_en, bus.m_we}, 32'b1110);
    tick();
    idle();
    #3;
    chk("pri_rresp", 32'(bus.c_rresp), 32'd1);
    chk("pri_drain0", {bus.m_we, bus.m_addr}, {1'b1, 30'h10});
    tick();
    #3;
    chk("pri_drain1", {bus.m_we, bus.m_addr}, {1'b1, 30'h11});
    tick();
    #3;
    chk("pri_idle", 32'(bus.m_en), 32'd0);
    tick();

    // Same-cycle write and read of one word.
    drive(1'b1, 32'h30, 32'hC0C0C0C0, 4'hF, 1'b1, 32'h30);
    #3;
    chk("same_cyc", {bus.c_wvalid, bus.c_rvalid, bus.m_en}, 32'b100);
    tick();
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h30);
    #3;
    chk("same_drain", {bus.c_rvalid, bus.m_we, bus.m_addr}, {1'b0, 1'b1, 30'hC});
    wait_rvalid("same", 6);
    chk("same_rdata", bus.c_rdata, 32'hC0C0C0C0);
    tick();

    // Reset with three stores buffered discards them.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h60 + 32'(4 * i), 32'hE0E0E000 + 32'(i), 4'hF, 1'b1, 32'h100);
      tick();
    end
    idle();
    #1;
    chk("mid_busy_pre", 32'(bus.wb_busy), 32'd1);
    resetb = 1'b0;
    #1;
    chk("mid_rst_now", {bus.m_en, bus.wb_busy, bus.wb_full, bus.c_rresp}, 32'd0);
    @(negedge clk);
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk($sformatf("post_rst_men%0d", i), 32'(bus.m_en), 32'd0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h64);
    #3;
    wait_rvalid("post_rst_rd", 3);
    chk("post_rst_rdata", bus.c_rdata, 32'd0);
    repeat (4) tick();

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
